// File: rtl/eth_frame_checker.sv
// Receive-side Ethernet frame checker: parses a control-tagged byte stream, forwards
// payload with framing strobes, flags preamble/length faults and keeps frame statistics.
module eth_frame_checker #(
  parameter int          MIN_PREAMBLE   = 6,
  parameter int          MAX_PREAMBLE   = 8,
  parameter int          MIN_DATA       = 46,
  parameter int          MAX_DATA       = 1500,
  parameter logic [7:0]  IDLE_CODE      = 8'h07,
  parameter logic [7:0]  START_CODE     = 8'hFB,
  parameter logic [7:0]  PREAMBLE_CODE  = 8'h55,
  parameter logic [7:0]  SFD_CODE       = 8'hD5,
  parameter logic [7:0]  TERMINATE_CODE = 8'hFD
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_ctrl,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_frame_good,
  output logic        o_frame_bad,
  output logic [2:0]  o_err_code,
  output logic [15:0] o_data_count,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt
);

  localparam logic [7:0]  MIN_PRE_C  = 8'(MIN_PREAMBLE);
  localparam logic [7:0]  MAX_PRE_C  = 8'(MAX_PREAMBLE);
  localparam logic [15:0] MIN_DATA_C = 16'(MIN_DATA);
  localparam logic [15:0] MAX_DATA_C = 16'(MAX_DATA);

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_SHORT_PRE = 3'd1;
  localparam logic [2:0] ERR_BAD_PRE   = 3'd2;
  localparam logic [2:0] ERR_LONG_PRE  = 3'd3;
  localparam logic [2:0] ERR_RUNT      = 3'd4;
  localparam logic [2:0] ERR_GIANT     = 3'd5;
  localparam logic [2:0] ERR_CTRL      = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} state_t;

  state_t      state_r, state_s;
  logic [7:0]  pre_cnt_r, pre_cnt_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic        sof_r, sof_s;
  logic        eof_r, eof_s;
  logic        good_r, good_s;
  logic        bad_r, bad_s;
  logic [2:0]  err_r, err_s;
  logic [15:0] data_cnt_r, data_cnt_s;
  logic [15:0] good_cnt_r, good_cnt_s;
  logic [15:0] bad_cnt_r, bad_cnt_s;

  logic is_data_s;
  assign is_data_s = !i_rx_ctrl;

  // Next-state, strobe and counter computation for the received byte
  always_comb begin
    state_s    = state_r;
    pre_cnt_s  = pre_cnt_r;
    data_s     = data_r;
    valid_s    = 1'b0;
    sof_s      = 1'b0;
    eof_s      = 1'b0;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    err_s      = err_r;
    data_cnt_s = data_cnt_r;
    good_cnt_s = good_cnt_r;
    bad_cnt_s  = bad_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (i_rx_ctrl && (i_rx_data == START_CODE)) begin
          state_s   = ST_PREAMBLE;
          pre_cnt_s = 8'd0;
        end else if (is_data_s && (i_rx_data == PREAMBLE_CODE)) begin
          state_s   = ST_PREAMBLE;
          pre_cnt_s = 8'd1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (is_data_s && (i_rx_data == PREAMBLE_CODE)) begin
          if (pre_cnt_r >= MAX_PRE_C) begin
            bad_s   = 1'b1;
            err_s   = ERR_LONG_PRE;
            state_s = ST_DROP;
          end else begin
            pre_cnt_s = pre_cnt_r + 8'd1;
          end
        end else if (is_data_s && (i_rx_data == SFD_CODE)) begin
          if (pre_cnt_r >= MIN_PRE_C) begin
            state_s    = ST_DATA;
            data_cnt_s = 16'd0;
            err_s      = ERR_NONE;
          end else begin
            bad_s   = 1'b1;
            err_s   = ERR_SHORT_PRE;
            state_s = ST_IDLE;
          end
        end else begin
          bad_s   = 1'b1;
          err_s   = ERR_BAD_PRE;
          state_s = ST_DROP;
        end
      end
      ST_DATA: begin
        if (is_data_s) begin
          if (data_cnt_r < MAX_DATA_C) begin
            data_s     = i_rx_data;
            valid_s    = 1'b1;
            sof_s      = (data_cnt_r == 16'd0);
            data_cnt_s = data_cnt_r + 16'd1;
          end else begin
            bad_s   = 1'b1;
            err_s   = ERR_GIANT;
            state_s = ST_DROP;
          end
        end else if (i_rx_data == TERMINATE_CODE) begin
          eof_s   = 1'b1;
          state_s = ST_IDLE;
          if (data_cnt_r >= MIN_DATA_C) begin
            good_s = 1'b1;
          end else begin
            bad_s = 1'b1;
            err_s = ERR_RUNT;
          end
        end else begin
          eof_s   = 1'b1;
          bad_s   = 1'b1;
          err_s   = ERR_CTRL;
          state_s = (i_rx_data == IDLE_CODE) ? ST_IDLE : ST_DROP;
        end
      end
      ST_DROP: begin
        if (i_rx_ctrl && ((i_rx_data == IDLE_CODE) || (i_rx_data == TERMINATE_CODE))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Statistics saturate rather than wrap
    if (good_s && (good_cnt_r != 16'hFFFF)) begin
      good_cnt_s = good_cnt_r + 16'd1;
    end else begin
      good_cnt_s = good_cnt_r;
    end
    if (bad_s && (bad_cnt_r != 16'hFFFF)) begin
      bad_cnt_s = bad_cnt_r + 16'd1;
    end else begin
      bad_cnt_s = bad_cnt_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      pre_cnt_r  <= 8'd0;
      data_r     <= 8'd0;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
      good_r     <= 1'b0;
      bad_r      <= 1'b0;
      err_r      <= 3'd0;
      data_cnt_r <= 16'd0;
      good_cnt_r <= 16'd0;
      bad_cnt_r  <= 16'd0;
    end else begin
      state_r    <= state_s;
      pre_cnt_r  <= pre_cnt_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      sof_r      <= sof_s;
      eof_r      <= eof_s;
      good_r     <= good_s;
      bad_r      <= bad_s;
      err_r      <= err_s;
      data_cnt_r <= data_cnt_s;
      good_cnt_r <= good_cnt_s;
      bad_cnt_r  <= bad_cnt_s;
    end
  end

  assign o_data       = data_r;
  assign o_data_valid = valid_r;
  assign o_sof        = sof_r;
  assign o_eof        = eof_r;
  assign o_frame_good = good_r;
  assign o_frame_bad  = bad_r;
  assign o_err_code   = err_r;
  assign o_data_count = data_cnt_r;
  assign o_good_cnt   = good_cnt_r;
  assign o_bad_cnt    = bad_cnt_r;

endmodule

// File: tb/tb_eth_frame_checker.sv
// Self-checking bench for eth_frame_checker: a directed vector table for preamble
// faults plus hand-written frame sequences for length, truncation, reset and saturation.
module tb_eth_frame_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_ctrl;
  logic [7:0]  o_data;
  logic        o_data_valid, o_sof, o_eof, o_frame_good, o_frame_bad;
  logic [2:0]  o_err_code;
  logic [15:0] o_data_count, o_good_cnt, o_bad_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  eth_frame_checker #(.MAX_DATA(64)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_ctrl(i_rx_ctrl),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_frame_good(o_frame_good), .o_frame_bad(o_frame_bad), .o_err_code(o_err_code),
    .o_data_count(o_data_count), .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
  );

  always #5 clk = ~clk;

  // exp packs {valid, sof, eof, good, bad, err[2:0]}
  typedef struct {
    logic       ctrl;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  int beats, sofs, sof_bad, data_err, bad_idx;
  logic [2:0] bad_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic c, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.ctrl = c; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    i_rx_ctrl = c;
    i_rx_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {o_data_valid, o_sof, o_eof, o_frame_good, o_frame_bad, o_err_code};
  endfunction

  // Preamble plus SFD plus nd incrementing payload bytes starting at b; records what came out
  task automatic send_body(input int npre, input int nd, input logic [7:0] b);
    logic [7:0] exp_b;
    for (int i = 0; i < npre; i++) drive(1'b0, 8'h55);
    drive(1'b0, 8'hD5);
    beats = 0; sofs = 0; sof_bad = 0; data_err = 0; bad_idx = -1; bad_err = 3'd0;
    for (int i = 0; i < nd; i++) begin
      exp_b = b + 8'(i);
      drive(1'b0, exp_b);
      if (o_data_valid) begin
        beats++;
        if (o_data !== exp_b) data_err++;
      end
      if (o_sof) begin
        sofs++;
        if (!(o_data_valid && beats == 1)) sof_bad++;
      end
      if (o_frame_bad && bad_idx < 0) begin
        bad_idx = i;
        bad_err = o_err_code;
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; i_rx_ctrl = 1'b1; i_rx_data = 8'h07;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {24'd0, strobes()}, 32'd0);
    chk("reset_data", {24'd0, o_data}, 32'd0);
    chk("reset_counts", {o_data_count, o_good_cnt}, 32'd0);
    chk("reset_bad_cnt", {16'd0, o_bad_cnt}, 32'd0);
    i_rst = 1'b1;

    // Preamble faults: short, long (then dropped), bad byte (then dropped)
    add_vec(1'b1, 8'h07, 8'h00);
    add_vec(1'b0, 8'h55, 8'h00);
    add_vec(1'b0, 8'h55, 8'h00);
    add_vec(1'b0, 8'h55, 8'h00);
    add_vec(1'b0, 8'hD5, 8'h09);
    add_vec(1'b1, 8'h07, 8'h01);
    for (int i = 0; i < 8; i++) add_vec(1'b0, 8'h55, 8'h01);
    add_vec(1'b0, 8'h55, 8'h0B);
    add_vec(1'b0, 8'hD5, 8'h03);
    add_vec(1'b0, 8'hAA, 8'h03);
    add_vec(1'b1, 8'h07, 8'h03);
    add_vec(1'b0, 8'hAA, 8'h03);
    add_vec(1'b1, 8'hFB, 8'h03);
    add_vec(1'b0, 8'h55, 8'h03);
    add_vec(1'b0, 8'h12, 8'h0A);
    add_vec(1'b0, 8'hD5, 8'h02);
    add_vec(1'b1, 8'hFD, 8'h02);
    add_vec(1'b1, 8'h07, 8'h02);
    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].data);
      chk($sformatf("vec%0d", i), {24'd0, strobes()}, {24'd0, vecs[i].exp});
    end
    chk("pre_bad_cnt", {o_good_cnt, o_bad_cnt}, {16'd0, 16'd3});

    // Nominal frame, exactly MIN_DATA bytes
    repeat (4) drive(1'b1, 8'h07);
    send_body(7, 46, 8'h10);
    chk("nom_beats", beats, 46);
    chk("nom_sof", {sofs[15:0], sof_bad[15:0]}, {16'd1, 16'd0});
    chk("nom_data", data_err, 0);
    drive(1'b1, 8'hFD);
    chk("nom_term", {24'd0, strobes()}, {24'd0, 8'b0011_0000});
    chk("nom_counts", {o_data_count, o_good_cnt}, {16'd46, 16'd1});
    drive(1'b1, 8'h07);
    chk("nom_pulse_end", {24'd0, strobes()}, 32'd0);

    // Runt
    send_body(7, 45, 8'h20);
    drive(1'b1, 8'hFD);
    chk("runt_term", {24'd0, strobes()}, {24'd0, 8'b0010_1100});
    chk("runt_counts", {o_good_cnt, o_bad_cnt}, {16'd1, 16'd4});

    // Giant with MAX_DATA=64: 65 bytes, trailing terminate is silent
    drive(1'b1, 8'h07);
    send_body(7, 65, 8'h40);
    chk("giant_beats", beats, 64);
    chk("giant_bad", {bad_idx[15:0], 13'd0, bad_err}, {16'd64, 16'd5});
    chk("giant_count", {o_data_count, o_bad_cnt}, {16'd64, 16'd5});
    drive(1'b1, 8'hFD);
    chk("giant_trail", {24'd0, strobes()}, {24'd0, 8'h05});
    drive(1'b1, 8'h07);

    // Truncation by IDLE inside payload
    send_body(7, 20, 8'h60);
    drive(1'b1, 8'h07);
    chk("trunc_term", {24'd0, strobes()}, {24'd0, 8'b0010_1110});
    chk("trunc_counts", {o_data_count, o_bad_cnt}, {16'd20, 16'd6});
    send_body(7, 46, 8'h70);
    drive(1'b1, 8'hFD);
    chk("after_trunc_good", {o_frame_good, o_good_cnt}, {1'b1, 16'd2});

    // Reset mid-frame
    drive(1'b1, 8'h07);
    send_body(7, 10, 8'h80);
    i_rst = 1'b0;
    drive(1'b0, 8'h8A);
    chk("rst_strobes", {16'd0, o_data, strobes()}, 32'd0);
    chk("rst_counts", {o_data_count, o_good_cnt}, 32'd0);
    chk("rst_bad_cnt", {16'd0, o_bad_cnt}, 32'd0);
    i_rst = 1'b1;
    drive(1'b1, 8'h07);
    send_body(7, 50, 8'h90);
    drive(1'b1, 8'hFD);
    chk("post_rst_good", {o_frame_good, o_good_cnt, o_data_count[7:0]}, {1'b1, 16'd1, 8'd50});

    // Back-to-back frames with zero idle gap
    send_body(7, 46, 8'hA0);
    drive(1'b1, 8'hFD);
    chk("b2b_first", {o_frame_good, o_good_cnt}, {1'b1, 16'd2});
    send_body(7, 46, 8'hB0);
    chk("b2b_second_beats", beats, 46);
    drive(1'b1, 8'hFD);
    chk("b2b_second", {o_frame_good, o_good_cnt}, {1'b1, 16'd3});
    drive(1'b1, 8'h07);

    // Bad counter saturation
    force dut.bad_cnt_r = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.bad_cnt_r;
    drive(1'b1, 8'h07);
    chk("sat_preload", {16'd0, o_bad_cnt}, {16'd0, 16'hFFFE});
    send_body(7, 10, 8'hC0);
    drive(1'b1, 8'hFD);
    chk("sat_first", {16'd0, o_bad_cnt}, {16'd0, 16'hFFFF});
    send_body(7, 10, 8'hD0);
    drive(1'b1, 8'hFD);
    chk("sat_hold", {15'd0, o_frame_bad, o_bad_cnt}, {15'd0, 1'b1, 16'hFFFF});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eth_frame_checker.md
Name: eth_frame_checker

Overview:
- Receive-side counterpart of the team's byte-wide Ethernet frame generator.
- Parses a byte-per-clock stream of idle, preamble, SFD, data and terminate characters, each tagged with a control flag.
- Forwards payload bytes with framing strobes, checks preamble and length rules, and keeps saturating good/bad frame counters.
- Sits at the far end of the generator link in loopback benches and in front of the future MAC receive path.

Parameters:
- MIN_PREAMBLE, 6, minimum 0x55 bytes accepted before SFD.
- MAX_PREAMBLE, 8, maximum 0x55 bytes accepted before SFD.
- MIN_DATA, 46, minimum payload bytes for a good frame.
- MAX_DATA, 1500, maximum payload bytes for a good frame.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- PREAMBLE_CODE, 8'h55, preamble data byte.
- SFD_CODE, 8'hD5, start-of-frame delimiter data byte.
- TERMINATE_CODE, 8'hFD, terminate control character.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_rx_data  in  8  received byte.
- i_rx_ctrl  in  1  1 = i_rx_data is a control character, 0 = data byte.
- o_data  out  8  payload byte.
- o_data_valid  out  1  o_data holds a payload byte.
- o_sof  out  1  first payload byte of a frame (with o_data_valid).
- o_eof  out  1  frame ended (good or bad), single-cycle pulse.
- o_frame_good  out  1  pulse with o_eof, frame passed all checks.
- o_frame_bad  out  1  pulse, frame failed a check.
- o_err_code  out  3  error cause; held until the next frame's SFD.
- o_data_count  out  16  payload bytes of the current/last frame.
- o_good_cnt  out  16  good frames, saturating at 16'hFFFF.
- o_bad_cnt  out  16  bad frames, saturating at 16'hFFFF.

Behaviour:
- Reset (i_rst=0 at a clk edge): state IDLE; all outputs and internal counters 0. Reset mid-frame abandons the frame with no good/bad pulse and no counter update.
- Outputs are registered: the response to the input sampled at edge N appears after edge N, i.e. 1-cycle latency.
- Error codes: 0 none, 1 short preamble, 2 bad preamble byte, 3 long preamble, 4 runt (<MIN_DATA), 5 giant (>MAX_DATA), 6 unexpected control character in data.
- FSM states IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - ctrl=1 with START_CODE -> PREAMBLE, preamble count 0.
  - ctrl=0 with PREAMBLE_CODE -> PREAMBLE, preamble count 1.
  - Anything else is ignored.
- PREAMBLE:
  - ctrl=0 with 0x55 -> count+1. If the count would exceed MAX_PREAMBLE, flag bad with error 3 and go to DROP.
  - ctrl=0 with SFD_CODE and count >= MIN_PREAMBLE -> DATA; clear o_data_count and o_err_code.
  - SFD with count < MIN_PREAMBLE -> bad, error 1, go to IDLE.
  - Any other byte -> bad, error 2, go to DROP.
- DATA:
  - ctrl=0 byte: if o_data_count < MAX_DATA, forward it with o_data_valid=1 and increment o_data_count. o_sof=1 on the first forwarded byte.
  - ctrl=0 byte with o_data_count == MAX_DATA: not forwarded; bad, error 5, go to DROP.
  - ctrl=1 TERMINATE_CODE:
    - If o_data_count >= MIN_DATA: o_eof=1, o_frame_good=1, o_good_cnt+1.
    - Otherwise: o_eof=1, o_frame_bad=1, error 4.
    - Either way, go to IDLE.
  - Any other ctrl=1 character -> o_eof=1, bad, error 6. Go to IDLE if the character is IDLE_CODE, otherwise go to DROP.
- DROP: discard bytes until ctrl=1 with IDLE_CODE or TERMINATE_CODE, then go to IDLE. No further pulses for this frame.
- Every bad outcome: exactly one o_frame_bad pulse per frame, o_bad_cnt+1 (saturating). o_eof pulses on bad outcomes only when a frame had reached DATA.
- Boundary conditions:
  - TERMINATE exactly at count MAX_DATA is good.
  - TERMINATE exactly at count MIN_DATA is good.
  - A new START/0x55 in the same cycle as TERMINATE is not possible (one byte per cycle). The byte after TERMINATE is evaluated in IDLE, so back-to-back frames work with zero idle gap.
- o_data holds its last value when o_data_valid=0. o_data_count, o_err_code and the statistics counters are stable between events.

Test Plan:
- Nominal: 0x07 x4, 0x55 x7, 0xD5, 0xAA x46, 0xFD(ctrl) -> 46 valid beats of 0xAA, o_sof on the first, o_eof+o_frame_good 1 cycle after 0xFD, o_data_count=46, o_good_cnt=1, o_err_code=0.
- Runt: nominal frame with 45 data bytes -> o_frame_bad pulse, o_err_code=4, o_bad_cnt=1, o_good_cnt unchanged.
- Preamble faults:
  - 3 x 0x55 then 0xD5 -> bad, error 1, no o_data_valid.
  - 9 x 0x55 -> bad, error 3 on the 9th byte; the following 0xD5/data is dropped until idle.
- Giant: MAX_DATA set to 64, send 65 data bytes -> 64 valid beats, bad with error 5 on the 65th, o_data_count=64; trailing 0xFD produces no pulse.
- Truncation and reset:
  - 0x07(ctrl) after 20 data bytes -> o_eof+o_frame_bad, error 6, back in IDLE.
  - Separately, i_rst=0 after 10 data bytes -> all outputs 0 next cycle; the next nominal frame is received good.
- Back-to-back and saturation: two nominal frames with zero idle gap -> two good pulses. Preload o_bad_cnt to 16'hFFFF via 65535 runts (or force) -> stays 16'hFFFF.
